// File: rtl/serial_nibble_loader_pkg.sv
// Shared types and constants for the serial nibble loader.
// LOADER_PARITY_EN adds one even-parity bit after each word.
package loader_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} loader_state_t;

   localparam int DEFAULT_WIDTH = 4;

`ifdef LOADER_PARITY_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/serial_nibble_loader_shift_reg.sv
// Serial-in shift register for the nibble loader. With LOOKAHEAD set, the
// word output already includes din, so the final bit can be captured on its own edge.
module nibble_shift_reg
   import loader_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit LOOKAHEAD = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift_en,
   input  logic             clear,
   input  logic             din,
   output logic [WIDTH-1:0] word
);

   generate
      if (LOOKAHEAD) begin : g_la
         // The last bit never needs storing, so only WIDTH-1 bits are held.
         logic [WIDTH-2:0] r_sr;
         logic [WIDTH-1:0] w_shifted;

         assign w_shifted = MSB_FIRST ? {r_sr, din} : {din, r_sr};
         assign word      = w_shifted;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_sr <= '0;
            end else if (clear) begin
               r_sr <= '0;
            end else if (shift_en) begin
               r_sr <= MSB_FIRST ? w_shifted[WIDTH-2:0] : w_shifted[WIDTH-1:1];
            end
         end
      end else begin : g_reg
         logic [WIDTH-1:0] r_sr;
         logic [WIDTH-1:0] w_shifted;

         assign w_shifted = MSB_FIRST ? {r_sr[WIDTH-2:0], din} : {din, r_sr[WIDTH-1:1]};
         assign word      = r_sr;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_sr <= '0;
            end else if (clear) begin
               r_sr <= '0;
            end else if (shift_en) begin
               r_sr <= w_shifted;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/serial_nibble_loader.sv
// Serial-to-parallel loader feeding the 4-bit register stage.
// Optional even-parity check after each word under LOADER_PARITY_EN.
//
// state | meaning
// IDLE  | no bits of the current word received yet
// SHIFT | collecting data (and parity) bits
// HOLD  | complete word presented, waiting for nib_ready
module serial_nibble_loader
   import loader_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                                    clk,
   input  logic                                    rest,
   input  logic                                    sin_valid,
   input  logic                                    sin_data,
   output logic                                    sin_ready,
   output logic                                    nib_valid,
   output logic [WIDTH-1:0]                        nib_data,
   input  logic                                    nib_ready,
   output logic [$clog2(WIDTH+1+PARITY_BITS)-1:0]  bit_cnt,
   output logic                                    busy
`ifdef LOADER_PARITY_EN
   ,
   output logic                                    par_err
`endif
);

   localparam int CNT_W = $clog2(WIDTH + 1 + PARITY_BITS);
   localparam logic [CNT_W-1:0] DATA_CNT  = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] FINAL_IDX = CNT_W'(WIDTH + PARITY_BITS - 1);

   logic [1:0]       r_rst_sync;
   logic             w_rst_n;
   loader_state_t    r_state, w_state_nxt;
   logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
   logic [WIDTH-1:0] r_nib_data, w_sr_word;
   logic             w_sin_ready, w_shift_en, w_clear, w_load;

   // Reset asserts immediately, releases two edges after rest rises.
   always_ff @(posedge clk or negedge rest) begin
      if (!rest) r_rst_sync <= 2'b00;
      else       r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   nibble_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST),
      .LOOKAHEAD (PARITY_BITS == 0)
   ) u_shift_reg (
      .clk      (clk),
      .rst_n    (w_rst_n),
      .shift_en (w_shift_en),
      .clear    (w_clear),
      .din      (sin_data),
      .word     (w_sr_word)
   );

`ifdef LOADER_PARITY_EN
   logic w_par_fail, r_par_err;
`endif

   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_sin_ready   = 1'b0;
      w_shift_en    = 1'b0;
      w_clear       = 1'b0;
      w_load        = 1'b0;
`ifdef LOADER_PARITY_EN
      w_par_fail    = 1'b0;
`endif
      case (r_state)
         IDLE, SHIFT: begin
            w_sin_ready = 1'b1;
            if (sin_valid) begin
               w_state_nxt   = SHIFT;
               w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
               w_shift_en    = (r_bit_cnt < DATA_CNT);
               if (r_bit_cnt == FINAL_IDX) begin
                  w_clear = 1'b1;
`ifdef LOADER_PARITY_EN
                  if (^{w_sr_word, sin_data}) begin
                     w_par_fail    = 1'b1;
                     w_state_nxt   = IDLE;
                     w_bit_cnt_nxt = '0;
                  end else begin
                     w_load      = 1'b1;
                     w_state_nxt = HOLD;
                  end
`else
                  w_load      = 1'b1;
                  w_state_nxt = HOLD;
`endif
               end
            end
         end
         HOLD: begin
            if (nib_ready) begin
               w_state_nxt   = IDLE;
               w_bit_cnt_nxt = '0;
            end
         end
         default: begin
            w_state_nxt   = IDLE;
            w_bit_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state    <= IDLE;
         r_bit_cnt  <= '0;
         r_nib_data <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         if (w_load) r_nib_data <= w_sr_word;
      end
   end

`ifdef LOADER_PARITY_EN
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) r_par_err <= 1'b0;
      else          r_par_err <= w_par_fail;
   end
   assign par_err = r_par_err;
`endif

   assign sin_ready = w_sin_ready;
   assign nib_valid = (r_state == HOLD);
   assign nib_data  = r_nib_data;
   assign bit_cnt   = r_bit_cnt;
   assign busy      = (r_state != IDLE);

endmodule
